// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch block and its next-PC helper.
//   state_t  : fetch FSM encoding (FETCH=0, HOLD=1)
//   PC_INCR  : sequential PC step in bytes
//   BR_SHIFT : word-offset to byte-offset shift for branch targets
package instr_fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int unsigned PC_INCR  = 4;
  localparam int unsigned BR_SHIFT = 2;

endpackage

// File: rtl/instr_fetch_next_pc.sv
// Next-PC selection for the retiring instruction.
//   currentpc     : PC of the retiring instruction
//   extimm        : sign-extended branch offset in words
//   branch        : conditional-branch control
//   uncond_branch : unconditional-branch control
//   zero          : ALU zero flag
//   npc           : branch target or sequential PC (modulo 2^ADDR_W)
module next_pc
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] currentpc,
  input  logic [ADDR_W-1:0] extimm,
  input  logic              branch,
  input  logic              uncond_branch,
  input  logic              zero,
  output logic [ADDR_W-1:0] npc
);

  logic taken;

  assign taken = uncond_branch | (branch & zero);

  // Plain unsigned add; a negative offset in two's complement wraps to a
  // backward target, and overflow past the top of memory wraps silently.
  assign npc = taken ? currentpc + (extimm << BR_SHIFT)
                     : currentpc + ADDR_W'(PC_INCR);

endmodule

// File: rtl/instr_fetch.sv
// Single-issue instruction fetch: request a word, hold it until retired,
// then step or branch the PC and fetch again.
//   CLK, Reset           : clock, synchronous active-high reset
//   startpc              : PC loaded during reset
//   imem_req/addr        : fetch request and address (address = currentpc)
//   imem_ready/rdata     : memory response
//   inst, opcode         : instruction register and inst[31:21]
//   inst_valid           : inst holds an un-retired instruction
//   retire, branch, uncond_branch, zero, extimm : retire and branch controls
//   currentpc            : PC of the held / in-flight instruction
//   retired_count        : retired instruction counter (wraps)
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] startpc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst,
  output logic [10:0]       opcode,
  output logic              inst_valid,
  input  logic              retire,
  input  logic              branch,
  input  logic              uncond_branch,
  input  logic              zero,
  input  logic [ADDR_W-1:0] extimm,
  output logic [ADDR_W-1:0] currentpc,
  output logic [31:0]       retired_count
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] npc;
  logic              load_inst, do_retire;

  next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
    .currentpc    (currentpc),
    .extimm       (extimm),
    .branch       (branch),
    .uncond_branch(uncond_branch),
    .zero         (zero),
    .npc          (npc)
  );

  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    load_inst  = 1'b0;
    do_retire  = 1'b0;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          load_inst = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        inst_valid = 1'b1;
        if (retire) begin
          do_retire = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state         <= FETCH;
      currentpc     <= startpc;
      inst          <= '0;
      retired_count <= '0;
    end else begin
      state <= state_nxt;
      if (load_inst) inst <= imem_rdata;
      if (do_retire) begin
        currentpc     <= npc;
        retired_count <= retired_count + 32'd1;
      end
    end
  end

  assign imem_addr = currentpc;
  assign opcode    = inst[31:21];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, fetch latency, memory wait,
// sequential / branch retire, reset mid-fetch, retire in FETCH, PC wrap.
module tb_instr_fetch;

  localparam int ADDR_W = 64;
  localparam int INST_W = 32;

  logic              CLK = 1'b0;
  logic              Reset;
  logic [ADDR_W-1:0] startpc;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [INST_W-1:0] imem_rdata;
  logic [INST_W-1:0] inst;
  logic [10:0]       opcode;
  logic              inst_valid;
  logic              retire, branch, uncond_branch, zero;
  logic [ADDR_W-1:0] extimm;
  logic [ADDR_W-1:0] currentpc;
  logic [31:0]       retired_count;

  int n_chk  = 0;
  int n_fail = 0;

  instr_fetch #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
    .CLK(CLK), .Reset(Reset), .startpc(startpc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .inst(inst), .opcode(opcode), .inst_valid(inst_valid),
    .retire(retire), .branch(branch), .uncond_branch(uncond_branch),
    .zero(zero), .extimm(extimm),
    .currentpc(currentpc), .retired_count(retired_count)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [INST_W-1:0] d);
    imem_ready = 1'b1;
    imem_rdata = d;
    tick();
    imem_ready = 1'b0;
  endtask

  task automatic do_retire(input logic b, input logic u, input logic z,
                           input logic [ADDR_W-1:0] imm);
    branch = b; uncond_branch = u; zero = z; extimm = imm;
    retire = 1'b1;
    tick();
    retire = 1'b0; branch = 1'b0; uncond_branch = 1'b0; zero = 1'b0;
    extimm = '0;
  endtask

  task automatic do_reset(input logic [ADDR_W-1:0] pc);
    startpc = pc;
    Reset   = 1'b1;
    tick();
    Reset   = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; startpc = 64'h100;
    imem_ready = 1'b0; imem_rdata = '0;
    retire = 1'b0; branch = 1'b0; uncond_branch = 1'b0; zero = 1'b0;
    extimm = '0;
    tick(); tick();

    // reset state
    chk("rst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst",  64'(inst), 64'd0);
    chk("rst_pc",    currentpc, 64'h100);
    chk("rst_count", 64'(retired_count), 64'd0);

    // first request in first Reset=0 cycle, ready immediately
    Reset = 1'b0;
    chk("first_req",  64'(imem_req), 64'd1);
    chk("first_addr", imem_addr, 64'h100);
    fetch(32'h8B020020);
    chk("f1_valid",  64'(inst_valid), 64'd1);
    chk("f1_opcode", 64'(opcode), 64'h458);
    chk("f1_req",    64'(imem_req), 64'd0);
    chk("f1_inst",   64'(inst), 64'h8B020020);

    // ready ignored in HOLD
    fetch(32'h12345678);
    chk("hold_inst",  64'(inst), 64'h8B020020);
    chk("hold_valid", 64'(inst_valid), 64'd1);

    // sequential retire at 0x100
    do_retire(1'b0, 1'b0, 1'b0, '0);
    chk("seq_addr",  imem_addr, 64'h104);
    chk("seq_req",   64'(imem_req), 64'd1);
    chk("seq_valid", 64'(inst_valid), 64'd0);
    chk("seq_count", 64'(retired_count), 64'd1);

    // 0x104 -> 0x108, then uncond branch -2 words -> 0x100
    fetch(32'h0);
    do_retire(1'b0, 1'b0, 1'b0, '0);
    chk("seq2_addr", imem_addr, 64'h108);
    fetch(32'h14000000);
    do_retire(1'b0, 1'b1, 1'b0, -64'sd2);
    chk("ub_addr",  imem_addr, 64'h100);
    chk("ub_count", 64'(retired_count), 64'd3);

    // memory wait 3 cycles at 0x100
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("wait%0d_addr", i),  imem_addr, 64'h100);
      chk($sformatf("wait%0d_req", i),   64'(imem_req), 64'd1);
      chk($sformatf("wait%0d_valid", i), 64'(inst_valid), 64'd0);
    end
    fetch(32'hB4000060);
    chk("wait_done_valid", 64'(inst_valid), 64'd1);

    // conditional branch taken: 0x100 + 3*4
    do_retire(1'b1, 1'b0, 1'b1, 64'd3);
    chk("bz_addr",  imem_addr, 64'h10C);
    chk("bz_count", 64'(retired_count), 64'd4);

    // back to 0x100, then branch not taken -> 0x104
    fetch(32'h0);
    do_retire(1'b0, 1'b1, 1'b0, -64'sd3);
    chk("back_addr", imem_addr, 64'h100);
    fetch(32'h0);
    do_retire(1'b1, 1'b0, 1'b0, 64'd3);
    chk("bnz_addr",  imem_addr, 64'h104);
    chk("bnz_count", 64'(retired_count), 64'd6);

    // retire pulse during FETCH is ignored
    do_retire(1'b0, 1'b1, 1'b0, 64'd8);
    chk("fretire_addr",  imem_addr, 64'h104);
    chk("fretire_count", 64'(retired_count), 64'd6);
    chk("fretire_req",   64'(imem_req), 64'd1);

    // reset beats imem_ready mid-fetch
    startpc = 64'h200; Reset = 1'b1;
    imem_ready = 1'b1; imem_rdata = 32'hDEADBEEF;
    tick();
    Reset = 1'b0; imem_ready = 1'b0;
    chk("rr_valid", 64'(inst_valid), 64'd0);
    chk("rr_inst",  64'(inst), 64'd0);
    chk("rr_pc",    currentpc, 64'h200);
    chk("rr_count", 64'(retired_count), 64'd0);
    chk("rr_req",   64'(imem_req), 64'd1);

    // PC wrap at top of address space
    do_reset(64'hFFFF_FFFF_FFFF_FFFC);
    fetch(32'h0);
    do_retire(1'b0, 1'b0, 1'b0, '0);
    chk("wrap_addr",  imem_addr, 64'h0);
    chk("wrap_count", 64'(retired_count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
